// File: rtl/skid_pipe_reg_pkg.sv
// Shared types for the elastic skid pipeline register.
package skid_pipe_reg_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b10
  } skid_state_t;

  localparam int unsigned OCC_W = 2;

  function automatic logic [OCC_W-1:0] skid_occ(input skid_state_t s);
    case (s)
      BUSY:    return 2'd1;
      FULL:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/skid_pipe_stage.sv
// One two-entry skid stage: main drives the output, skid absorbs the
// single entry that arrives while the output is stalled.
module skid_pipe_stage
  import skid_pipe_reg_pkg::*;
#(
  parameter int             N           = 32,
  parameter logic [N-1:0]   RESET_VALUE = '0,
  parameter logic [N-1:0]   CLR_VALUE   = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data,
  output logic [OCC_W-1:0] occ_next
);

  skid_state_t  state_p0, state_nxt;
  logic [N-1:0] main_p0, main_nxt;
  logic [N-1:0] skid_p0, skid_nxt;
  logic         in_fire, out_fire;

  assign in_ready  = (state_p0 != FULL);
  assign out_valid = (state_p0 != EMPTY);
  assign out_data  = main_p0;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  // Occupancy after the coming edge, so the registered count lines up with state.
  assign occ_next  = skid_occ(state_nxt);

  always_comb begin
    state_nxt = state_p0;
    main_nxt  = main_p0;
    skid_nxt  = skid_p0;
    if (flush) begin
      state_nxt = EMPTY;
      main_nxt  = CLR_VALUE;
      skid_nxt  = CLR_VALUE;
    end else begin
      case (state_p0)
        EMPTY: begin
          if (in_fire) begin
            state_nxt = BUSY;
            main_nxt  = in_data;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            main_nxt = in_data;
          end else if (in_fire) begin
            state_nxt = FULL;
            skid_nxt  = in_data;
          end else if (out_fire) begin
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_nxt = BUSY;
            main_nxt  = skid_p0;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Stage register boundary
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_p0 <= EMPTY;
      main_p0  <= RESET_VALUE;
      skid_p0  <= RESET_VALUE;
    end else begin
      state_p0 <= state_nxt;
      main_p0  <= main_nxt;
      skid_p0  <= skid_nxt;
    end
  end

endmodule

// File: rtl/skid_pipe_reg.sv
// Elastic pipeline register: STAGES cascaded skid stages with registered
// ready/data paths and a registered total-occupancy count.
module skid_pipe_reg
  import skid_pipe_reg_pkg::*;
#(
  parameter int           N           = 32,
  parameter int           STAGES      = 1,
  parameter logic [N-1:0] RESET_VALUE = '0,
  parameter logic [N-1:0] CLR_VALUE   = '0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             flush,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [N-1:0]                     in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [N-1:0]                     out_data,
  output logic [$clog2(2*STAGES+1)-1:0]    count
);

  localparam int CNT_W = $clog2(2*STAGES+1);

  logic             vld_p  [STAGES+1];
  logic             rdy_p  [STAGES+1];
  logic [N-1:0]     data_p [STAGES+1];
  logic [OCC_W-1:0] occ_p  [STAGES];
  logic [CNT_W-1:0] occ_sum;

  assign vld_p[0]       = in_valid;
  assign data_p[0]      = in_data;
  assign in_ready       = rdy_p[0];
  assign out_valid      = vld_p[STAGES];
  assign out_data       = data_p[STAGES];
  assign rdy_p[STAGES]  = out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    skid_pipe_stage #(
      .N           (N),
      .RESET_VALUE (RESET_VALUE),
      .CLR_VALUE   (CLR_VALUE)
    ) u_stage (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (vld_p[k]),
      .in_ready  (rdy_p[k]),
      .in_data   (data_p[k]),
      .out_valid (vld_p[k+1]),
      .out_ready (rdy_p[k+1]),
      .out_data  (data_p[k+1]),
      .occ_next  (occ_p[k])
    );
  end

  always_comb begin
    occ_sum = '0;
    for (int k = 0; k < STAGES; k++) begin
      occ_sum = occ_sum + CNT_W'(occ_p[k]);
    end
  end

  // Count register boundary
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else begin
      count <= occ_sum;
    end
  end

endmodule

// File: tb/tb_skid_pipe_reg.sv
// Bench for skid_pipe_reg: directed phases plus random traffic, checked
// against a FIFO-queue reference model of the block contents.
module tb_skid_pipe_reg;

  localparam int           N      = 32;
  localparam int           STAGES = 3;
  localparam int           DEPTH  = 2 * STAGES;
  localparam int           CW     = $clog2(DEPTH + 1);
  localparam logic [N-1:0] RST_V  = 32'h0BAD_F00D;
  localparam logic [N-1:0] CLR_V  = 32'hC1EA_0000;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [N-1:0]  in_data, out_data;
  logic [CW-1:0] count;

  int            checks = 0;
  int            passed = 0;
  int            accepted = 0;
  logic [N-1:0]  q [$];
  logic          in_fire_s, out_fire_s;
  logic [N-1:0]  in_data_s;

  always #5 clk = ~clk;

  skid_pipe_reg #(
    .N           (N),
    .STAGES      (STAGES),
    .RESET_VALUE (RST_V),
    .CLR_VALUE   (CLR_V)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Mid-cycle: compare DUT against the queue model, then sample the handshakes.
  task automatic at_neg();
    @(negedge clk);
    chk("count_vs_model", N'(count), N'(q.size()));
    if (q.size() == 0) chk("valid_when_empty", N'(out_valid), N'(0));
    if (out_valid && q.size() != 0) chk("head_data", out_data, q[0]);
    if (q.size() == DEPTH) chk("ready_when_full", N'(in_ready), N'(0));
    in_fire_s  = in_valid & in_ready;
    out_fire_s = out_valid & out_ready;
    in_data_s  = in_data;
  endtask

  task automatic at_pos();
    @(posedge clk);
    if (reset || flush) begin
      q.delete();
    end else begin
      if (out_fire_s && q.size() != 0) void'(q.pop_front());
      if (in_fire_s) begin
        q.push_back(in_data_s);
        accepted++;
      end
    end
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;

    // Reset values
    #12;
    chk("rst_out_valid", N'(out_valid), N'(0));
    chk("rst_in_ready", N'(in_ready), N'(1));
    chk("rst_count", N'(count), N'(0));
    chk("rst_out_data", out_data, RST_V);
    @(posedge clk); #1;
    reset = 1'b0;

    out_ready = 1'b1;
    at_neg();
    chk("idle_data_reset", out_data, RST_V);
    at_pos();

    // Streaming with out_ready high: latency and gap-free throughput
    for (int c = 0; c < 8 + STAGES + 2; c++) begin
      in_valid = (c < 8);
      in_data  = N'(c + 1);
      at_neg();
      chk("stream_valid", N'(out_valid), N'(c >= STAGES && c < STAGES + 8));
      if (c >= STAGES && c < STAGES + 8) chk("stream_data", out_data, N'(c - STAGES + 1));
      if (c < 8) chk("stream_ready", N'(in_ready), N'(1));
      at_pos();
    end
    in_valid = 1'b0;
    at_neg();
    chk("hold_last", out_data, N'(8));
    at_pos();

    // Fill under backpressure, then drain
    out_ready = 1'b0;
    accepted  = 0;
    in_valid  = 1'b1;
    for (int c = 0; c < 20; c++) begin
      in_data = N'(32'hA0 + accepted);
      at_neg();
      if (accepted == DEPTH) chk("fill_ready_low", N'(in_ready), N'(0));
      at_pos();
    end
    chk("fill_accepted", N'(accepted), N'(DEPTH));
    out_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      in_data  = N'(32'hA0 + accepted);
      in_valid = (accepted <= DEPTH);
      at_neg();
      if (c == 0) begin
        chk("full_drain_no_accept", N'(in_ready), N'(0));
        chk("full_drain_out_valid", N'(out_valid), N'(1));
      end
      at_pos();
    end
    in_valid = 1'b0;
    chk("fill_resume", N'(accepted), N'(DEPTH + 1));
    at_neg();
    chk("drain_empty_valid", N'(out_valid), N'(0));
    chk("drain_hold", out_data, N'(32'hA0 + DEPTH));
    at_pos();

    // Random valid/ready traffic
    for (int c = 0; c < 10000; c++) begin
      in_valid  = ($urandom_range(99) < 60);
      out_ready = ($urandom_range(99) < ((c < 5000) ? 50 : 80));
      in_data   = $urandom;
      at_neg();
      at_pos();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      at_neg();
      at_pos();
    end
    at_neg();
    chk("random_drained", N'(count), N'(0));
    at_pos();

    // Flush while holding 5 entries, with a concurrent input offered
    out_ready = 1'b0;
    accepted  = 0;
    for (int c = 0; c < 20; c++) begin
      in_valid = (accepted < 5);
      in_data  = N'(32'hF0 + accepted);
      at_neg();
      at_pos();
    end
    in_valid = 1'b0;
    chk("flush_pre_accepted", N'(accepted), N'(5));
    flush = 1'b1; in_valid = 1'b1; in_data = 32'h55; out_ready = 1'b1;
    at_neg();
    at_pos();
    flush = 1'b0; in_valid = 1'b0;
    at_neg();
    chk("flush_out_valid", N'(out_valid), N'(0));
    chk("flush_count", N'(count), N'(0));
    chk("flush_out_data", out_data, CLR_V);
    chk("flush_in_ready", N'(in_ready), N'(1));
    at_pos();
    for (int c = 0; c < 8; c++) begin
      at_neg();
      chk("flush_no_ghost", N'(out_valid), N'(0));
      at_pos();
    end

    // Asynchronous reset while full
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int c = 0; c < 20; c++) begin
      in_data = $urandom;
      at_neg();
      at_pos();
    end
    in_valid = 1'b0;
    at_neg();
    chk("pre_reset_full", N'(count), N'(DEPTH));
    #2;
    reset = 1'b1;
    #1;
    q.delete();
    chk("arst_out_valid", N'(out_valid), N'(0));
    chk("arst_in_ready", N'(in_ready), N'(1));
    chk("arst_count", N'(count), N'(0));
    chk("arst_out_data", out_data, RST_V);
    at_pos();
    reset = 1'b0;
    out_ready = 1'b1;
    accepted  = 0;
    for (int c = 0; c < 12; c++) begin
      in_valid = (c < 4);
      in_data  = N'(32'hB0 + c);
      at_neg();
      if (c == 0) chk("post_reset_ready", N'(in_ready), N'(1));
      at_pos();
    end
    in_valid = 1'b0;
    chk("post_reset_accepted", N'(accepted), N'(4));

    // Flush and reset together
    reset = 1'b1; flush = 1'b1;
    at_neg();
    at_pos();
    at_neg();
    chk("flush_reset_data", out_data, RST_V);
    chk("flush_reset_count", N'(count), N'(0));
    at_pos();
    reset = 1'b0; flush = 1'b0;
    at_neg();
    chk("after_flush_reset_data", out_data, RST_V);
    at_pos();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/skid_pipe_reg.md
# skid_pipe_reg

Parametrised elastic pipeline register: a chain of `STAGES` two-entry skid-buffer stages carrying an `N`-bit payload under a valid/ready handshake, with synchronous flush.

- Successor to the plain enable/clear register. It adds per-stage backpressure, full throughput, and registered `in_ready`/`out_data`, so there is no combinational path from input to output.
- Used between core pipeline stages and on the SoC bus wherever the timing of the ready path must be cut.

## Interface
Parameters:
- `N`, 32, payload width in bits, ≥1.
- `STAGES`, 1, number of cascaded skid stages, ≥1.
- `RESET_VALUE`, 0, value loaded into every data register on reset.
- `CLR_VALUE`, 0, value loaded into every data register on flush (the bubble payload).

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `flush`  in  1  synchronous clear of all contents.
- `in_valid`  in  1  upstream has data.
- `in_ready`  out  1  block accepts data; driven from state flops only.
- `in_data`  in  N  upstream payload.
- `out_valid`  out  1  head entry present.
- `out_ready`  in  1  downstream accepts.
- `out_data`  out  N  head payload; driven directly from the stage `main` register.
- `count`  out  $clog2(2*STAGES+1)  total entries held.

## Operation
- A handshake fires when valid and ready are both high at a rising edge: `in_fire = in_valid & in_ready` and `out_fire = out_valid & out_ready`.
- Each stage holds a `main` register (drives its output) and a `skid` register, plus state EMPTY, BUSY or FULL.
  - Stage `in_ready = (state != FULL)`.
  - Stage `out_valid = (state != EMPTY)`.
- Stage transitions, flush not asserted:
  - EMPTY, in_fire → BUSY; `main <= in`.
  - BUSY, in_fire and no out_fire → FULL; `skid <= in`.
  - BUSY, in_fire and out_fire → BUSY; `main <= in`.
  - BUSY, out_fire and no in_fire → EMPTY.
  - FULL, out_fire → BUSY; `main <= skid`. No in_fire is possible in FULL.
  - Any other combination holds state and data.
- Stage k's output feeds stage k+1's input; stage 0 takes the block input, and stage `STAGES-1` drives the block output.
- Ordering is strict FIFO. The block never drops or duplicates an entry.
- Flush has the highest priority after reset.
  - Every stage goes to EMPTY.
  - Every `main` and `skid` register loads `CLR_VALUE`.
  - An in_fire or out_fire in the flush cycle is discarded: the upstream producer sees it as accepted, and downstream must ignore `out_data` that cycle.
- `count` is the sum of stage occupancies (EMPTY=0, BUSY=1, FULL=2), registered, range 0..2*STAGES.

## Timing
- Reset values, applied asynchronously while `reset` is high:
  - every stage EMPTY;
  - `out_valid=0`, `in_ready=1`, `count=0`, `out_data=RESET_VALUE`.
- Latency: with `out_ready` held high, data presented with in_fire at edge t appears with `out_valid=1` after edge t+STAGES-1. Equivalently, it is visible `STAGES` cycles after presentation.
- Throughput: one item per cycle sustained while `out_ready=1`. There are no bubbles at stage boundaries.
- Backpressure:
  - With `out_ready=0`, `in_ready` falls in the cycle after the 2*STAGES-th entry is accepted.
  - `in_ready` rises in the cycle after the first out_fire frees space in stage 0. The chain propagates one entry per stage per cycle.
- Full with `out_ready` and `in_valid` both high: out_fire occurs and stage 0 does not accept that cycle. Acceptance resumes next cycle.
- Empty with `out_ready` high: no out_fire. `out_data` holds its last value, or `RESET_VALUE`/`CLR_VALUE` after reset or flush.
- Reset asserted mid-transfer: contents are lost immediately. The first accept after deassertion follows the first clock edge.
- Flush and reset together: reset wins.

## Structure
- Add to the shared types package: enum `skid_state_t` {EMPTY=2'b00, BUSY=2'b01, FULL=2'b10}.
- Sub-module `skid_pipe_stage` (parameters `N`, `RESET_VALUE`, `CLR_VALUE`) implements one stage and exports its 2-bit occupancy.
- Top level: generate loop over `STAGES`, occupancy adder tree, registered `count`.

## Test plan
- Streaming: N=32, STAGES=2, `out_ready=1`, push 0x1..0x8 on consecutive cycles → out 0x1..0x8 in order, first output 2 cycles after the first push, no gaps, `count` stays ≤2.
- Fill: STAGES=2, `out_ready=0`, push 0xA0..0xA4 → exactly 4 accepted, `in_ready=0` from the cycle after the 4th accept, `count=4`; then `out_ready=1` → 0xA0..0xA3 drain, 0xA4 accepted once `in_ready` rises.
- Random backpressure: random `in_valid`/`out_ready` for 10k cycles against a scoreboard queue → no loss, reorder or duplicate; `count` equals the model depth every cycle.
- Flush: STAGES=3 holding 5 entries, pulse `flush` with `in_valid=1` and `in_data=0x55` → next cycle `out_valid=0`, `count=0`, `out_data=CLR_VALUE`; 0x55 never appears.
- Reset mid-stream: assert `reset` asynchronously between edges while full → `out_valid=0`, `in_ready=1`, `count=0` and `out_data=RESET_VALUE` before the next edge; normal streaming resumes after deassertion.
- Flush with reset: hold `flush=1` and `reset=1` together → reset values, not `CLR_VALUE`, on `out_data`.
